// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter stepped by rising edges of inc/dec, with wrap/saturate,
// synchronous load and cascade pulses. Define MOD_UPDOWN_SEVENSEG_EN for segs decode.
module mod_updown_counter #(
  parameter int MODULO    = 8,
  parameter int WIDTH     = $clog2(MODULO),
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             at_max,
  output logic             at_min,
  output logic [6:0]       segs
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_dn_q, wrap_dn_d;
  logic             inc_q, dec_q;
  logic             inc_e, dec_e;

  assign inc_e = inc & ~inc_q;
  assign dec_e = dec & ~dec_q;

  always_comb begin
    count_d   = count_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    if (load) begin
      count_d = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end else if (en && (inc_e ^ dec_e)) begin
      if (inc_e) begin
        if (count_q == MAX_VAL) begin
          if (!sat_mode) begin
            count_d   = '0;
            wrap_up_d = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          if (!sat_mode) begin
            count_d   = MAX_VAL;
            wrap_dn_d = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // Edge registers reset high so a button held through reset never steps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q   <= RST_VAL;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      inc_q     <= 1'b1;
      dec_q     <= 1'b1;
    end else begin
      count_q   <= count_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      inc_q     <= inc;
      dec_q     <= dec;
    end
  end

  assign count   = count_q;
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;
  assign at_max  = (count_q == MAX_VAL);
  assign at_min  = (count_q == '0);

`ifdef MOD_UPDOWN_SEVENSEG_EN
  logic [3:0] seg_idx;
  logic [6:0] segs_d;

  assign seg_idx = 4'(count_q);

  // Active-high segments ordered {g,f,e,d,c,b,a}.
  always_comb begin
    segs_d = 7'h00;
    case (seg_idx)
      4'h0: segs_d = 7'h3F;
      4'h1: segs_d = 7'h06;
      4'h2: segs_d = 7'h5B;
      4'h3: segs_d = 7'h4F;
      4'h4: segs_d = 7'h66;
      4'h5: segs_d = 7'h6D;
      4'h6: segs_d = 7'h7D;
      4'h7: segs_d = 7'h07;
      4'h8: segs_d = 7'h7F;
      4'h9: segs_d = 7'h6F;
      4'hA: segs_d = 7'h77;
      4'hB: segs_d = 7'h7C;
      4'hC: segs_d = 7'h39;
      4'hD: segs_d = 7'h5E;
      4'hE: segs_d = 7'h79;
      4'hF: segs_d = 7'h71;
      default: segs_d = 7'h00;
    endcase
  end

  assign segs = segs_d;
`else
  assign segs = 7'b0000000;
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter (MODULO=8, WIDTH=4 so out-of-range loads can be driven).
module tb_mod_updown_counter;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       inc;
  logic       dec;
  logic       sat_mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       wrap_up;
  logic       wrap_dn;
  logic       at_max;
  logic       at_min;
  logic [6:0] segs;

  mod_updown_counter #(.MODULO(8), .WIDTH(4), .RESET_VAL(0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .inc(inc), .dec(dec),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .count(count),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .at_max(at_max), .at_min(at_min),
    .segs(segs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
    bit         up;
    bit         dn;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] exp_segs(input logic [3:0] c);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef MOD_UPDOWN_SEVENSEG_EN
    return tbl[c];
`else
    return (tbl[c] == 7'h00) ? 7'h7F : 7'h00;
`endif
  endfunction

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare whenever an expectation is due.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, "count",   8'(count),   8'(e.cnt));
        chk(e.name, "wrap_up", 8'(wrap_up), 8'(e.up));
        chk(e.name, "wrap_dn", 8'(wrap_dn), 8'(e.dn));
        chk(e.name, "at_max",  8'(at_max),  8'(e.cnt == 4'd7));
        chk(e.name, "at_min",  8'(at_min),  8'(e.cnt == 4'd0));
        chk(e.name, "segs",    8'(segs),    8'(exp_segs(e.cnt)));
        $display("txn cyc=%0d %s count=%0d up=%0b dn=%0b segs=%02h", cyc, e.name, count, wrap_up, wrap_dn, segs);
      end else if (exp_q[0].cyc < cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
      end
    end
  end

  task automatic step(input bit rn, input bit e, input bit i, input bit d, input bit s,
                      input bit l, input logic [3:0] lv, input logic [3:0] ec,
                      input bit eu, input bit ed, input string nm);
    exp_t x;
    reset_n  = rn;
    en       = e;
    inc      = i;
    dec      = d;
    sat_mode = s;
    load     = l;
    load_val = lv;
    x.cyc  = cyc + 1;
    x.cnt  = ec;
    x.up   = eu;
    x.dn   = ed;
    x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; inc = 1'b0; dec = 1'b0;
    sat_mode = 1'b0; load = 1'b0; load_val = 4'd0;
    @(posedge clk);
    #1;
    // reset with inc held: no step on release
    step(0, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, "rst_a");
    step(0, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, "rst_b");
    step(1, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, "rst_rel_inc_held");
    step(1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, "inc_rel");
    // eight presses wrap 7 -> 0
    for (int k = 1; k <= 8; k++) begin
      step(1, 1, 1, 0, 0, 0, 0, 4'(k % 8), (k == 8), 0, $sformatf("up_press%0d", k));
      step(1, 1, 0, 0, 0, 0, 0, 4'(k % 8), 0, 0, $sformatf("up_rel%0d", k));
    end
    step(1, 1, 0, 1, 0, 0, 0, 4'd7, 0, 1, "dec_wrap");
    step(1, 1, 0, 0, 0, 0, 0, 4'd7, 0, 0, "dec_wrap_off");
    step(1, 1, 1, 0, 0, 0, 0, 4'd0, 1, 0, "inc_wrap");
    step(1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, "inc_wrap_off");
    step(1, 1, 0, 1, 1, 0, 0, 4'd0, 0, 0, "sat_dec_min");
    step(1, 1, 0, 0, 1, 0, 0, 4'd0, 0, 0, "sat_dec_rel");
    step(1, 1, 0, 0, 1, 1, 7, 4'd7, 0, 0, "load7");
    step(1, 1, 1, 0, 1, 0, 0, 4'd7, 0, 0, "sat_inc_max");
    step(1, 1, 0, 0, 1, 0, 0, 4'd7, 0, 0, "sat_inc_rel");
    step(1, 1, 0, 1, 0, 0, 0, 4'd6, 0, 0, "dec_plain");
    step(1, 1, 0, 0, 0, 0, 0, 4'd6, 0, 0, "dec_plain_rel");
    // held inc from 3 steps once
    step(1, 1, 0, 0, 0, 1, 3, 4'd3, 0, 0, "load3");
    step(1, 1, 1, 0, 0, 0, 0, 4'd4, 0, 0, "hold_first");
    for (int k = 2; k <= 10; k++)
      step(1, 1, 1, 0, 0, 0, 0, 4'd4, 0, 0, $sformatf("hold%0d", k));
    step(1, 1, 0, 0, 0, 0, 0, 4'd4, 0, 0, "hold_rel");
    // load beats a same-cycle edge; out-of-range load clamps
    step(1, 1, 1, 0, 0, 1, 5, 4'd5, 0, 0, "load5_with_inc");
    step(1, 1, 1, 0, 0, 0, 0, 4'd5, 0, 0, "after_load_inc_held");
    step(1, 1, 0, 0, 0, 0, 0, 4'd5, 0, 0, "after_load_rel");
    step(1, 1, 0, 0, 0, 1, 12, 4'd7, 0, 0, "load12_clamp");
    step(1, 1, 0, 0, 0, 0, 0, 4'd7, 0, 0, "load12_hold");
    // simultaneous edges and disabled edges
    step(1, 1, 0, 0, 0, 1, 3, 4'd3, 0, 0, "load3b");
    step(1, 1, 1, 1, 0, 0, 0, 4'd3, 0, 0, "both_edges");
    step(1, 1, 0, 0, 0, 0, 0, 4'd3, 0, 0, "both_rel");
    step(1, 0, 1, 0, 0, 0, 0, 4'd3, 0, 0, "en0_edge");
    step(1, 1, 1, 0, 0, 0, 0, 4'd3, 0, 0, "en1_edge_lost");
    step(1, 1, 0, 0, 0, 0, 0, 4'd3, 0, 0, "en_rel");
    step(1, 1, 1, 0, 0, 0, 0, 4'd4, 0, 0, "en_recover");
    step(1, 1, 0, 0, 0, 0, 0, 4'd4, 0, 0, "en_recover_rel");
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
